// File: rtl/mips_irq_pkg.sv
// Shared types and constants for the mips789 interrupt controller.
package mips_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } irq_state_e;

  localparam int NSRC_DEF = 4;
  localparam int IDW_DEF  = 2;

  localparam int IRQ_TMR     = 0;
  localparam int IRQ_KEY1    = 1;
  localparam int IRQ_KEY2    = 2;
  localparam int IRQ_UART_RX = 3;

endpackage

// File: rtl/mips_irq_prio.sv
// Fixed-priority encoder: the lowest set request index wins.
module mips_irq_prio #(
  parameter int NSRC = 4,
  parameter int IDW  = 2
) (
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [IDW-1:0]  id
);

  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) id = IDW'(i);
    end
  end

endmodule

// File: rtl/mips_irq_ctl.sv
// Vectored interrupt controller: edge/level capture, masking, fixed priority,
// and a request/service/end-of-interrupt handshake with the core.
module mips_irq_ctl
  import mips_irq_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_i,
  input  logic [NSRC-1:0] edge_sel_i,
  input  logic [NSRC-1:0] en_i,
  input  logic            vec_we_i,
  input  logic [IDW-1:0]  vec_sel_i,
  input  logic [31:0]     vec_din_i,
  input  logic            irq_ack_i,
  input  logic            irq_eoi_i,
  output logic            irq_req_o,
  output logic [31:0]     irq_addr_o,
  output logic [IDW-1:0]  irq_id_o,
  output logic [NSRC-1:0] pend_o
);

  irq_state_e      state_q, state_d;
  logic [NSRC-1:0] src_d_q;
  logic [NSRC-1:0] epend_q, epend_d;
  logic [31:0]     vec_q [NSRC];
  logic [31:0]     vec_d [NSRC];
  logic            req_q, req_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [31:0]     addr_q, addr_d;

  logic [NSRC-1:0] pend, mpend, ack_clr;
  logic            win_valid;
  logic [IDW-1:0]  win_id;

  // Level sources pass straight through; edge sources come from the latch.
  assign pend  = (edge_sel_i & epend_q) | (~edge_sel_i & src_i);
  assign mpend = pend & en_i;

  mips_irq_prio #(.NSRC(NSRC), .IDW(IDW)) u_prio (
    .req   (mpend),
    .valid (win_valid),
    .id    (win_id)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    ack_clr = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_REQ;
          id_d    = win_id;
          addr_d  = vec_q[win_id];
        end
      end
      ST_REQ: begin
        // The core acked the id it was shown, so that id is frozen and cleared.
        if (irq_ack_i) begin
          state_d       = ST_SERV;
          ack_clr[id_q] = edge_sel_i[id_q];
        end else if (!win_valid) begin
          state_d = ST_IDLE;
        end else begin
          id_d   = win_id;
          addr_d = vec_q[win_id];
        end
      end
      ST_SERV: begin
        if (irq_eoi_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d == ST_REQ);
  end

  // A fresh edge in the ack cycle must survive the clear.
  assign epend_d = (epend_q & ~ack_clr) | (src_i & ~src_d_q & edge_sel_i);

  always_comb begin
    vec_d = vec_q;
    if (vec_we_i) vec_d[vec_sel_i] = vec_din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_d_q <= '0;
      epend_q <= '0;
      vec_q   <= '{default: '0};
      req_q   <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      src_d_q <= src_i;
      epend_q <= epend_d;
      vec_q   <= vec_d;
      req_q   <= req_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
    end
  end

  assign irq_req_o  = req_q;
  assign irq_addr_o = addr_q;
  assign irq_id_o   = id_q;
  assign pend_o     = pend;

endmodule
